itch_dir_sequencer: RTL and testbench
=====================================

ITCH_DIR_SEQUENCER -- requirements
Module: itch_dir_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, 32, width of statistics counters.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_data  input  8  ITCH byte stream (2-byte big-endian length prefix, then message).
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-007 SHALL have port dir_valid  output  1  decoded Stock Directory record available.
REQ-008 SHALL have port dir_ready  input  1  consumer accepts record when dir_valid && dir_ready.
REQ-009 SHALL have port dir_rec  output  struct  packed record: locate 16, tracking 16, timestamp 48, stock 64, market category, financial status, round lot size 32, round-lots-only, issue class 8, subtype 16, authenticity, SST indicator, IPO flag, LULD tier, ETP flag, ETP leverage 32, inverse indicator (enums 8 bits each).
REQ-010 SHALL have port len_err  output  1  one-cycle pulse on 'R' message with length != 39.
REQ-011 SHALL have port msg_cnt  output  CNT_W  messages framed since reset.
REQ-012 SHALL have port dir_cnt  output  CNT_W  Stock Directory records emitted since reset.

Function
REQ-013 SHALL implement FSM states LEN_HI, LEN_LO, TYPE, BODY, SKIP, EMIT; reset state LEN_HI.
REQ-014 SHALL in LEN_HI/LEN_LO capture the 16-bit length on each accepted byte; length 0 returns to LEN_HI without incrementing msg_cnt.
REQ-015 SHALL in TYPE increment msg_cnt; type 'R' with length 39 -> BODY; type 'R' otherwise -> pulse len_err, SKIP; other types -> SKIP; length 1 with non-'R' -> LEN_HI.
REQ-016 SHALL maintain an offset counter (type byte = offset 0) advancing only on accepted bytes; SKIP consumes remaining length-1 bytes then returns to LEN_HI.
REQ-017 SHALL in BODY load fields by ITCH 5.0 offsets: locate 1-2, tracking 3-4, timestamp 5-10, stock 11-18, market 19, financial 20, round lot 21-24, round-lots-only 25, class 26, subtype 27-28, authenticity 29, SST 30, IPO 31, LULD 32, ETP flag 33, leverage 34-37, inverse 38; multi-byte fields big-endian.
REQ-018 SHALL map single-byte enumerated fields through the shared package parse functions; unrecognised codes map to each enum's UNKNOWN member.
REQ-019 SHALL enter EMIT the cycle after offset 38 is accepted, asserting dir_valid with dir_rec stable until handshake.
REQ-020 SHALL hold in_ready=0 in EMIT; in_ready=1 in all other states.
REQ-021 SHALL on dir_valid && dir_ready increment dir_cnt, drop dir_valid, return to LEN_HI the next cycle.
REQ-022 SHALL tolerate in_valid gaps in any state with no state or counter change.
REQ-023 SHALL wrap msg_cnt and dir_cnt modulo 2^CNT_W.
REQ-024 SHALL not alter dir_rec outside BODY.

Reset
REQ-025 SHALL on rst_n low asynchronously force state LEN_HI, dir_valid=0, len_err=0, counters 0, offset 0, dir_rec all-zero; in_ready=1 after release.
REQ-026 SHALL discard any partial message or pending record on reset mid-operation; no record emitted for it.

Structure
REQ-027 SHALL place the record struct, FSM state enum, message type constant 'R', length constant 39, and all field enums/parse functions in the shared message package.
REQ-028 SHALL isolate byte-offset field capture in sub-module itch_dir_field_capture (inputs byte, offset, strobe; output record).

Verification
REQ-029 SHALL test: valid 'R' len 39, locate 0x0012, stock "AAPL    ", market 'Q' -> one dir_valid, fields exact, dir_cnt=1, msg_cnt=1.
REQ-030 SHALL test: 'A' len 36 then 'R' len 39 back-to-back -> 'A' skipped, one record, msg_cnt=2.
REQ-031 SHALL test: 'R' len 40 -> len_err single pulse, 40 bytes consumed, no dir_valid, next message framed correctly.
REQ-032 SHALL test: dir_ready low 10 cycles after record -> in_ready=0, dir_rec stable throughout; release -> dir_cnt=1, in_ready=1 next cycle.
REQ-033 SHALL test: market byte 'X', financial ' ' -> UNKNOWN members in dir_rec.
REQ-034 SHALL test: rst_n low at offset 20, then valid 'R' -> exactly one record from second message, counters count only it.

Source files
------------

// File: rtl/itch_dir_sequencer_pkg.sv
// Shared definitions for the ITCH 5.0 Stock Directory ('R') sequencer:
// framing constants, FSM encoding, field enums, parse functions and the record.
package itch_dir_sequencer_pkg;

   localparam logic [7:0]  MSG_TYPE_DIR = 8'h52;   // 'R'
   localparam logic [15:0] DIR_MSG_LEN  = 16'd39;
   localparam logic [15:0] DIR_LAST_OFS = 16'd38;

   typedef logic [2:0] state_t;
   localparam state_t ST_LEN_HI = 3'd0;
   localparam state_t ST_LEN_LO = 3'd1;
   localparam state_t ST_TYPE   = 3'd2;
   localparam state_t ST_BODY   = 3'd3;
   localparam state_t ST_SKIP   = 3'd4;
   localparam state_t ST_EMIT   = 3'd5;

   // UNKNOWN is encoding 0 in every enum so an all-zero record reads as "nothing decoded".
   typedef enum logic [7:0] {
      MKT_UNKNOWN   = 8'd0,
      MKT_NASDAQ_GS = 8'd1,
      MKT_NASDAQ_GM = 8'd2,
      MKT_NASDAQ_CM = 8'd3,
      MKT_NYSE      = 8'd4,
      MKT_NYSE_AMER = 8'd5,
      MKT_NYSE_ARCA = 8'd6,
      MKT_BATS      = 8'd7,
      MKT_IEX       = 8'd8,
      MKT_NA        = 8'd9
   } market_e;

   typedef enum logic [7:0] {
      FIN_UNKNOWN         = 8'd0,
      FIN_DEFICIENT       = 8'd1,
      FIN_DELINQUENT      = 8'd2,
      FIN_BANKRUPT        = 8'd3,
      FIN_SUSPENDED       = 8'd4,
      FIN_DEF_BANK        = 8'd5,
      FIN_DEF_DELINQ      = 8'd6,
      FIN_DELINQ_BANK     = 8'd7,
      FIN_DEF_DELINQ_BANK = 8'd8,
      FIN_CREATIONS_SUSP  = 8'd9,
      FIN_NORMAL          = 8'd10
   } fin_e;

   typedef enum logic [7:0] {
      YN_UNKNOWN = 8'd0,
      YN_YES     = 8'd1,
      YN_NO      = 8'd2
   } yn_e;

   typedef enum logic [7:0] {
      YNA_UNKNOWN = 8'd0,
      YNA_YES     = 8'd1,
      YNA_NO      = 8'd2,
      YNA_NA      = 8'd3
   } ynna_e;

   typedef enum logic [7:0] {
      AUTH_UNKNOWN = 8'd0,
      AUTH_LIVE    = 8'd1,
      AUTH_TEST    = 8'd2
   } auth_e;

   typedef enum logic [7:0] {
      LULD_UNKNOWN = 8'd0,
      LULD_TIER1   = 8'd1,
      LULD_TIER2   = 8'd2,
      LULD_NA      = 8'd3
   } luld_e;

   typedef struct packed {
      logic [15:0] locate;
      logic [15:0] tracking;
      logic [47:0] timestamp;
      logic [63:0] stock;
      market_e     market;
      fin_e        fin_status;
      logic [31:0] round_lot;
      yn_e         round_lots_only;
      logic [7:0]  issue_class;
      logic [15:0] subtype;
      auth_e       auth;
      ynna_e       sst;
      ynna_e       ipo;
      luld_e       luld;
      ynna_e       etp_flag;
      logic [31:0] etp_leverage;
      yn_e         inverse;
   } dir_rec_t;

   function automatic market_e parse_market(input logic [7:0] c);
      case (c)
         "Q":     return MKT_NASDAQ_GS;
         "G":     return MKT_NASDAQ_GM;
         "S":     return MKT_NASDAQ_CM;
         "N":     return MKT_NYSE;
         "A":     return MKT_NYSE_AMER;
         "P":     return MKT_NYSE_ARCA;
         "Z":     return MKT_BATS;
         "V":     return MKT_IEX;
         " ":     return MKT_NA;
         default: return MKT_UNKNOWN;
      endcase
   endfunction

   function automatic fin_e parse_fin(input logic [7:0] c);
      case (c)
         "D":     return FIN_DEFICIENT;
         "E":     return FIN_DELINQUENT;
         "Q":     return FIN_BANKRUPT;
         "S":     return FIN_SUSPENDED;
         "G":     return FIN_DEF_BANK;
         "H":     return FIN_DEF_DELINQ;
         "J":     return FIN_DELINQ_BANK;
         "K":     return FIN_DEF_DELINQ_BANK;
         "C":     return FIN_CREATIONS_SUSP;
         "N":     return FIN_NORMAL;
         default: return FIN_UNKNOWN;
      endcase
   endfunction

   function automatic yn_e parse_yn(input logic [7:0] c);
      case (c)
         "Y":     return YN_YES;
         "N":     return YN_NO;
         default: return YN_UNKNOWN;
      endcase
   endfunction

   function automatic ynna_e parse_ynna(input logic [7:0] c);
      case (c)
         "Y":     return YNA_YES;
         "N":     return YNA_NO;
         " ":     return YNA_NA;
         default: return YNA_UNKNOWN;
      endcase
   endfunction

   function automatic auth_e parse_auth(input logic [7:0] c);
      case (c)
         "P":     return AUTH_LIVE;
         "T":     return AUTH_TEST;
         default: return AUTH_UNKNOWN;
      endcase
   endfunction

   function automatic luld_e parse_luld(input logic [7:0] c);
      case (c)
         "1":     return LULD_TIER1;
         "2":     return LULD_TIER2;
         " ":     return LULD_NA;
         default: return LULD_UNKNOWN;
      endcase
   endfunction

endpackage

// File: rtl/itch_dir_sequencer_field_capture.sv
// Loads one Stock Directory body byte into the record slot selected by its
// message offset; multi-byte fields arrive most-significant byte first.
module itch_dir_field_capture
   import itch_dir_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  data_byte,
   input  logic [15:0] offset,
   input  logic        strobe,
   output dir_rec_t    rec
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the record is a plain register bank, not a RAM, so it can and does take the reset value.
         rec <= '0;
      end else if (strobe) begin
         case (offset)
            16'd1:   rec.locate[15:8]        <= data_byte;
            16'd2:   rec.locate[7:0]         <= data_byte;
            16'd3:   rec.tracking[15:8]      <= data_byte;
            16'd4:   rec.tracking[7:0]       <= data_byte;
            16'd5:   rec.timestamp[47:40]    <= data_byte;
            16'd6:   rec.timestamp[39:32]    <= data_byte;
            16'd7:   rec.timestamp[31:24]    <= data_byte;
            16'd8:   rec.timestamp[23:16]    <= data_byte;
            16'd9:   rec.timestamp[15:8]     <= data_byte;
            16'd10:  rec.timestamp[7:0]      <= data_byte;
            16'd11:  rec.stock[63:56]        <= data_byte;
            16'd12:  rec.stock[55:48]        <= data_byte;
            16'd13:  rec.stock[47:40]        <= data_byte;
            16'd14:  rec.stock[39:32]        <= data_byte;
            16'd15:  rec.stock[31:24]        <= data_byte;
            16'd16:  rec.stock[23:16]        <= data_byte;
            16'd17:  rec.stock[15:8]         <= data_byte;
            16'd18:  rec.stock[7:0]          <= data_byte;
            16'd19:  rec.market              <= parse_market(data_byte);
            16'd20:  rec.fin_status          <= parse_fin(data_byte);
            16'd21:  rec.round_lot[31:24]    <= data_byte;
            16'd22:  rec.round_lot[23:16]    <= data_byte;
            16'd23:  rec.round_lot[15:8]     <= data_byte;
            16'd24:  rec.round_lot[7:0]      <= data_byte;
            16'd25:  rec.round_lots_only     <= parse_yn(data_byte);
            16'd26:  rec.issue_class         <= data_byte;
            16'd27:  rec.subtype[15:8]       <= data_byte;
            16'd28:  rec.subtype[7:0]        <= data_byte;
            16'd29:  rec.auth                <= parse_auth(data_byte);
            16'd30:  rec.sst                 <= parse_ynna(data_byte);
            16'd31:  rec.ipo                 <= parse_ynna(data_byte);
            16'd32:  rec.luld                <= parse_luld(data_byte);
            16'd33:  rec.etp_flag            <= parse_ynna(data_byte);
            16'd34:  rec.etp_leverage[31:24] <= data_byte;
            16'd35:  rec.etp_leverage[23:16] <= data_byte;
            16'd36:  rec.etp_leverage[15:8]  <= data_byte;
            16'd37:  rec.etp_leverage[7:0]   <= data_byte;
            16'd38:  rec.inverse             <= parse_yn(data_byte);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/itch_dir_sequencer.sv
// Frames a length-prefixed ITCH byte stream, decodes Stock Directory ('R')
// messages into a record with a valid/ready handshake and skips everything else.
module itch_dir_sequencer
   import itch_dir_sequencer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             dir_valid,
   input  logic             dir_ready,
   output dir_rec_t         dir_rec,
   output logic             len_err,
   output logic [CNT_W-1:0] msg_cnt,
   output logic [CNT_W-1:0] dir_cnt
);

   state_t      state;
   logic [15:0] msg_len;
   logic [15:0] offset;
   logic        accept;
   logic        body_strobe;

   assign in_ready    = (state != ST_EMIT);
   assign dir_valid   = (state == ST_EMIT);
   assign accept      = in_valid && in_ready;
   assign body_strobe = accept && (state == ST_BODY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_LEN_HI;
         msg_len <= '0;
         offset  <= '0;
         len_err <= 1'b0;
         msg_cnt <= '0;
         dir_cnt <= '0;
      end else begin
         // NOTE: non-blocking throughout, so every branch below sees pre-edge values of state, offset and msg_len.
         len_err <= 1'b0;
         case (state)
            ST_LEN_HI: begin
               if (accept) begin
                  msg_len[15:8] <= in_data;
                  state         <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (accept) begin
                  msg_len[7:0] <= in_data;
                  offset       <= '0;
                  state        <= ({msg_len[15:8], in_data} == 16'd0) ? ST_LEN_HI : ST_TYPE;
               end
            end
            ST_TYPE: begin
               if (accept) begin
                  msg_cnt <= msg_cnt + CNT_W'(1);
                  offset  <= 16'd1;
                  if (in_data == MSG_TYPE_DIR && msg_len == DIR_MSG_LEN) begin
                     state <= ST_BODY;
                  end else begin
                     len_err <= (in_data == MSG_TYPE_DIR);
                     // A one-byte message has nothing left to skip.
                     state   <= (msg_len == 16'd1) ? ST_LEN_HI : ST_SKIP;
                  end
               end
            end
            ST_SKIP: begin
               if (accept) begin
                  offset <= offset + 16'd1;
                  if (offset == msg_len - 16'd1) state <= ST_LEN_HI;
               end
            end
            ST_BODY: begin
               if (accept) begin
                  offset <= offset + 16'd1;
                  if (offset == DIR_LAST_OFS) state <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (dir_ready) begin
                  dir_cnt <= dir_cnt + CNT_W'(1);
                  state   <= ST_LEN_HI;
               end
            end
            default: state <= ST_LEN_HI;
         endcase
      end
   end

   itch_dir_field_capture u_capture (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_byte (in_data),
      .offset    (offset),
      .strobe    (body_strobe),
      .rec       (dir_rec)
   );

endmodule

// File: tb/tb_itch_dir_sequencer.sv
// Self-checking bench: table of single-message vectors, directed multi-cycle
// corner cases and a randomized stream checked against a message-level model.
module tb_itch_dir_sequencer;
   import itch_dir_sequencer_pkg::*;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      int         len;
      logic [7:0] mtype;
      int         exp_msg;
      int         exp_rec;
      int         exp_err;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        dir_valid;
   logic        dir_ready;
   dir_rec_t    dir_rec;
   logic        len_err;
   logic [31:0] msg_cnt;
   logic [31:0] dir_cnt;

   logic     dir_ready_man;
   logic     rand_ready;
   logic     rnd_ready;
   int       gap_pct;
   int       n_cmp;
   int       n_fail;
   int       len_err_seen;
   dir_rec_t got_q[$];
   dir_rec_t held_mon;
   bit       holding;

   itch_dir_sequencer #(.CNT_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dir_valid (dir_valid),
      .dir_ready (dir_ready),
      .dir_rec   (dir_rec),
      .len_err   (len_err),
      .msg_cnt   (msg_cnt),
      .dir_cnt   (dir_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dir_ready = rand_ready ? rnd_ready : dir_ready_man;
   always @(posedge clk) begin
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Handshakes, len_err pulses and record stability are observed mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         holding = 1'b0;
      end else begin
         if (holding && dir_valid) check("rec_stable", 320'(dir_rec), 320'(held_mon));
         holding  = dir_valid && !dir_ready;
         held_mon = dir_rec;
         if (dir_valid && dir_ready) got_q.push_back(dir_rec);
         if (len_err) len_err_seen++;
      end
   end

   // Position of c in the code list, 1-based; 0 means unrecognised. Code lists
   // follow the declaration order of the matching package enum.
   function automatic logic [7:0] code_idx(input string codes, input logic [7:0] c);
      for (int i = 0; i < codes.len(); i++) if (8'(codes[i]) == c) return 8'(i + 1);
      return 8'd0;
   endfunction

   function automatic logic [63:0] be(input bq_t m, input int first, input int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) v = (v << 8) | 64'(m[first + i]);
      return v;
   endfunction

   function automatic dir_rec_t model_rec(input bq_t m);
      dir_rec_t r;
      r.locate          = 16'(be(m, 1, 2));
      r.tracking        = 16'(be(m, 3, 2));
      r.timestamp       = 48'(be(m, 5, 6));
      r.stock           = be(m, 11, 8);
      r.market          = market_e'(code_idx("QGSNAPZV ", m[19]));
      r.fin_status      = fin_e'(code_idx("DEQSGHJKCN", m[20]));
      r.round_lot       = 32'(be(m, 21, 4));
      r.round_lots_only = yn_e'(code_idx("YN", m[25]));
      r.issue_class     = m[26];
      r.subtype         = 16'(be(m, 27, 2));
      r.auth            = auth_e'(code_idx("PT", m[29]));
      r.sst             = ynna_e'(code_idx("YN ", m[30]));
      r.ipo             = ynna_e'(code_idx("YN ", m[31]));
      r.luld            = luld_e'(code_idx("12 ", m[32]));
      r.etp_flag        = ynna_e'(code_idx("YN ", m[33]));
      r.etp_leverage    = 32'(be(m, 34, 4));
      r.inverse         = yn_e'(code_idx("YN", m[38]));
      return r;
   endfunction

   function automatic bq_t make_msg(input logic [7:0] t, input int len);
      bq_t m;
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      if (len > 0) m[0] = t;
      return m;
   endfunction

   function automatic bq_t make_dir_msg();
      string cs = "QGSNAPZVDEHYNT12 X?";
      int    enum_ofs[10] = '{19, 20, 25, 29, 30, 31, 32, 33, 38, 38};
      bq_t   m = make_msg(MSG_TYPE_DIR, 39);
      foreach (enum_ofs[i]) m[enum_ofs[i]] = 8'(cs[$urandom_range(0, cs.len() - 1)]);
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && t < 500) begin
         tick();
         t++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, required 1", t);
      end
      tick();
      in_valid = 1'b0;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 3)) tick();
   endtask

   task automatic send_msg(input bq_t m);
      logic [15:0] len = 16'(m.size());
      send_byte(len[15:8]);
      send_byte(len[7:0]);
      foreach (m[i]) send_byte(m[i]);
   endtask

   task automatic wait_drain();
      int t = 0;
      while (dir_valid && t < 300) begin
         tick();
         t++;
      end
      check("drain_dir_valid", 320'(dir_valid), 320'(0));
      repeat (2) tick();
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      got_q.delete();
      len_err_seen = 0;
   endtask

   initial begin
      vec_t        vecs[$];
      bq_t         m;
      bq_t         m2;
      dir_rec_t    exp_q[$];
      dir_rec_t    held;
      logic [63:0] aapl = 64'h4141504C20202020;
      int          exp_msg, exp_err, m0, d0, e0, g0;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      dir_ready_man = 1'b1; rand_ready = 1'b0; gap_pct = 0;
      n_cmp = 0; n_fail = 0; len_err_seen = 0;

      repeat (3) tick();
      check("rst_dir_valid", 320'(dir_valid), 320'(0));
      check("rst_dir_rec", 320'(dir_rec), 320'(0));
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", 320'(in_ready), 320'(1));
      check("rst_len_err", 320'(len_err), 320'(0));
      check("rst_msg_cnt", 320'(msg_cnt), 320'(0));
      check("rst_dir_cnt", 320'(dir_cnt), 320'(0));

      // Basic AAPL record.
      m = make_dir_msg();
      m[1] = 8'h00; m[2] = 8'h12; m[19] = "Q";
      for (int i = 0; i < 8; i++) m[11 + i] = aapl[63 - 8 * i -: 8];
      send_msg(m);
      wait_drain();
      check("aapl_nrec", 320'(got_q.size()), 320'(1));
      if (got_q.size() > 0) begin
         check("aapl_locate", 320'(got_q[0].locate), 320'(16'h0012));
         check("aapl_stock", 320'(got_q[0].stock), 320'(aapl));
         check("aapl_market", 320'(got_q[0].market), 320'(MKT_NASDAQ_GS));
         check("aapl_rec", 320'(got_q[0]), 320'(model_rec(m)));
      end
      check("aapl_dir_cnt", 320'(dir_cnt), 320'(1));
      check("aapl_msg_cnt", 320'(msg_cnt), 320'(1));

      // 'A' then 'R' back-to-back.
      do_reset();
      send_msg(make_msg("A", 36));
      m = make_dir_msg();
      send_msg(m);
      wait_drain();
      check("ar_nrec", 320'(got_q.size()), 320'(1));
      if (got_q.size() > 0) check("ar_rec", 320'(got_q[0]), 320'(model_rec(m)));
      check("ar_msg_cnt", 320'(msg_cnt), 320'(2));
      check("ar_len_err", 320'(len_err_seen), 320'(0));

      // 'R' with length 40, then a good one.
      do_reset();
      send_msg(make_msg("R", 40));
      wait_drain();
      check("r40_len_err", 320'(len_err_seen), 320'(1));
      check("r40_nrec", 320'(got_q.size()), 320'(0));
      check("r40_msg_cnt", 320'(msg_cnt), 320'(1));
      m = make_dir_msg();
      send_msg(m);
      wait_drain();
      check("r40_next_nrec", 320'(got_q.size()), 320'(1));
      if (got_q.size() > 0) check("r40_next_rec", 320'(got_q[0]), 320'(model_rec(m)));
      check("r40_next_msg_cnt", 320'(msg_cnt), 320'(2));
      check("r40_next_dir_cnt", 320'(dir_cnt), 320'(1));

      // Consumer back-pressure for 10 cycles.
      do_reset();
      dir_ready_man = 1'b0;
      m = make_dir_msg();
      send_msg(m);
      check("bp_dir_valid", 320'(dir_valid), 320'(1));
      held = dir_rec;
      check("bp_rec", 320'(held), 320'(model_rec(m)));
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_in_ready", 320'(in_ready), 320'(0));
         check("bp_hold", 320'(dir_rec), 320'(held));
      end
      dir_ready_man = 1'b1;
      tick();
      check("bp_rel_dir_valid", 320'(dir_valid), 320'(0));
      check("bp_rel_in_ready", 320'(in_ready), 320'(1));
      check("bp_rel_dir_cnt", 320'(dir_cnt), 320'(1));

      // Unrecognised market and financial codes.
      do_reset();
      m = make_dir_msg();
      m[19] = "X"; m[20] = " ";
      send_msg(m);
      wait_drain();
      check("unk_nrec", 320'(got_q.size()), 320'(1));
      if (got_q.size() > 0) begin
         check("unk_market", 320'(got_q[0].market), 320'(MKT_UNKNOWN));
         check("unk_fin", 320'(got_q[0].fin_status), 320'(FIN_UNKNOWN));
         check("unk_rec", 320'(got_q[0]), 320'(model_rec(m)));
      end

      // Reset in the middle of a record body.
      do_reset();
      send_msg(make_msg("B", 3));
      m = make_dir_msg();
      m[1] = 8'hAB;
      send_byte(8'h00);
      send_byte(8'd39);
      for (int i = 0; i < 20; i++) send_byte(m[i]);
      rst_n = 1'b0;
      #1;
      check("mid_rst_msg_cnt", 320'(msg_cnt), 320'(0));
      check("mid_rst_dir_rec", 320'(dir_rec), 320'(0));
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      got_q.delete();
      len_err_seen = 0;
      m2 = make_dir_msg();
      send_msg(m2);
      wait_drain();
      check("mid_rst_nrec", 320'(got_q.size()), 320'(1));
      if (got_q.size() > 0) check("mid_rst_rec", 320'(got_q[0]), 320'(model_rec(m2)));
      check("mid_rst_msg_cnt2", 320'(msg_cnt), 320'(1));
      check("mid_rst_dir_cnt2", 320'(dir_cnt), 320'(1));

      // Single-message vectors with expected counter deltas.
      vecs = '{
         '{39, "R", 1, 1, 0}, '{36, "A", 1, 0, 0}, '{40, "R", 1, 0, 1},
         '{1,  "R", 1, 0, 1}, '{1,  "S", 1, 0, 0}, '{0,  "R", 0, 0, 0},
         '{38, "R", 1, 0, 1}, '{2,  "R", 1, 0, 1}, '{39, "E", 1, 0, 0}
      };
      gap_pct = 20;
      foreach (vecs[v]) begin
         m0 = int'(msg_cnt); d0 = int'(dir_cnt); e0 = len_err_seen; g0 = got_q.size();
         m = make_msg(vecs[v].mtype, vecs[v].len);
         send_msg(m);
         wait_drain();
         check($sformatf("vec%0d_msg", v), 320'(int'(msg_cnt) - m0), 320'(vecs[v].exp_msg));
         check($sformatf("vec%0d_dir", v), 320'(int'(dir_cnt) - d0), 320'(vecs[v].exp_rec));
         check($sformatf("vec%0d_err", v), 320'(len_err_seen - e0), 320'(vecs[v].exp_err));
         if (vecs[v].exp_rec == 1 && got_q.size() > g0)
            check($sformatf("vec%0d_rec", v), 320'(got_q[g0]), 320'(model_rec(m)));
      end

      // Randomized stream with input gaps and random consumer stalls.
      do_reset();
      rand_ready = 1'b1;
      gap_pct    = 30;
      exp_msg    = 0;
      exp_err    = 0;
      for (int k = 0; k < 60; k++) begin
         int kind = $urandom_range(0, 9);
         int len;
         if (kind < 5) begin
            m = make_dir_msg();
         end else if (kind == 5) begin
            len = $urandom_range(1, 60);
            if (len == 39) len = 40;
            m = make_msg("R", len);
         end else if (kind == 6) begin
            m = make_msg("R", 0);
         end else begin
            m = make_msg(8'($urandom_range(8'h41, 8'h51)), $urandom_range(1, 45));
         end
         if (m.size() > 0) exp_msg++;
         if (m.size() > 0 && m[0] == MSG_TYPE_DIR) begin
            if (m.size() == 39) exp_q.push_back(model_rec(m));
            else exp_err++;
         end
         send_msg(m);
      end
      wait_drain();
      check("rnd_nrec", 320'(got_q.size()), 320'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("rnd_rec%0d", i), 320'(got_q[i]), 320'(exp_q[i]));
      check("rnd_msg_cnt", 320'(msg_cnt), 320'(exp_msg));
      check("rnd_dir_cnt", 320'(dir_cnt), 320'(exp_q.size()));
      check("rnd_len_err", 320'(len_err_seen), 320'(exp_err));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
